// File: rtl/libfifo_pkg.sv
// Shared FIFO library types: fill flags seen by FIFO clients and the burst reader FSM states.
package libfifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
  } fillStatus_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } readerState_t;

endpackage

// File: rtl/fifoConnect.sv
// Connection bundle between a fifo core and its producer/consumer clients.
interface fifoConnect #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
);
  import libfifo_pkg::fillStatus_t;

  localparam int unsigned FILLBITS = $clog2(DEPTH + 1);

  logic                write;
  logic [WIDTH-1:0]    datain;
  logic                read;
  logic [WIDTH-1:0]    dataout;
  fillStatus_t         fillStatus;
  logic [FILLBITS-1:0] fillLevel;

  modport reader (output read, write, datain, input dataout, fillStatus, fillLevel);
  modport writer (output write, datain, input fillStatus, fillLevel);
  modport core   (input write, datain, read, output dataout, fillStatus, fillLevel);

endinterface

// File: rtl/stream_output_register.sv
// One-entry valid/ready output stage; can_load tells the source a new word may be captured now.
module stream_output_register #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             can_load
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             last_q;

  assign can_load = !valid_q || m_ready;
  assign m_data   = data_q;
  assign m_valid  = valid_q;
  assign m_last   = last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load) begin
      data_q  <= load_data;
      valid_q <= 1'b1;
      last_q  <= load_last;
    end else if (m_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a fifo through its reader port and re-emits the words as framed valid/ready bursts.
module fifo_burst_reader #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned BURST   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  fifoConnect.reader       link,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic [15:0]      bursts
);
  import libfifo_pkg::readerState_t;
  import libfifo_pkg::IDLE;
  import libfifo_pkg::DRAIN;

  localparam int unsigned FILLBITS = $clog2(DEPTH + 1);
  localparam int unsigned REMBITS  = $clog2(BURST + 1);
  localparam int unsigned TMRBITS  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [FILLBITS-1:0] BURST_FILL = FILLBITS'(BURST);
  localparam logic [REMBITS-1:0]  BURST_REM  = REMBITS'(BURST);
  localparam logic [TMRBITS-1:0]  TIMEOUT_T  = TMRBITS'(TIMEOUT);

  readerState_t       state_q, state_d;
  logic [REMBITS-1:0] remaining_q, remaining_d;
  logic [TMRBITS-1:0] timer_q, timer_d;
  logic               flush_pend_q, flush_pend_d;
  logic [15:0]        bursts_q, bursts_d;

  logic               can_load;
  logic               rd;
  logic               empty;
  logic               full_start;
  logic               part_start;
  logic               timeout_hit;
  logic [REMBITS-1:0] part_len;

  assign empty       = link.fillStatus.empty;
  assign full_start  = enable && (link.fillLevel >= BURST_FILL || link.fillStatus.full);
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TIMEOUT_T);
  assign part_start  = !empty && (flush || flush_pend_q || timeout_hit);
  assign part_len    = (link.fillLevel < BURST_FILL) ? REMBITS'(link.fillLevel) : BURST_REM;

  // Gated by reset so a reset cycle never pops a word that would then be discarded.
  assign rd = !reset && (state_q == libfifo_pkg::BURST) && !empty &&
              (remaining_q != '0) && can_load;

  assign link.read   = rd;
  assign link.write  = 1'b0;
  assign link.datain = '0;
  assign busy        = (state_q != IDLE);
  assign bursts      = bursts_q;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    timer_d      = '0;
    flush_pend_d = flush_pend_q;
    bursts_d     = bursts_q;
    unique case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        if (full_start) begin
          remaining_d = BURST_REM;
          state_d     = libfifo_pkg::BURST;
        end else if (part_start) begin
          remaining_d = part_len;
          state_d     = libfifo_pkg::BURST;
        end else if ((TIMEOUT != 0) && enable && !empty && (link.fillLevel < BURST_FILL)) begin
          timer_d = timer_q + 1'b1;
        end
      end
      libfifo_pkg::BURST: begin
        if (flush) flush_pend_d = 1'b1;
        if (rd) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == REMBITS'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (flush) flush_pend_d = 1'b1;
        if (m_valid && m_ready && m_last) begin
          bursts_d = bursts_q + 16'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
      bursts_q     <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      timer_q      <= timer_d;
      flush_pend_q <= flush_pend_d;
      bursts_q     <= bursts_d;
    end
  end

  stream_output_register #(
    .WIDTH(WIDTH)
  ) u_out (
    .clk      (clk),
    .reset    (reset),
    .load     (rd),
    .load_data(link.dataout),
    .load_last(remaining_q == REMBITS'(1)),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .can_load (can_load)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural 32-deep fifo behind the reader port.
module tb_fifo_burst_reader;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned BURST   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             flush;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic             busy;
  logic [15:0]      bursts;

  fifoConnect #(.WIDTH(WIDTH), .DEPTH(DEPTH)) link ();

  fifo_burst_reader #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .BURST  (BURST),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .flush  (flush),
    .link   (link),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last (m_last),
    .busy   (busy),
    .bursts (bursts)
  );

  always #5 clk = ~clk;

  // Behavioural fifo: not touched by the reader's reset.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [4:0]       wr_ptr = '0;
  logic [4:0]       rd_ptr = '0;
  logic [5:0]       count  = '0;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             do_push, do_pop;

  assign do_push         = push && (count != 6'd32);
  assign do_pop          = link.read && (count != 6'd0);
  assign link.dataout    = mem[rd_ptr];
  assign link.fillLevel  = count;
  assign link.fillStatus = {count == 6'd32, count == 6'd0};

  always @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= wr_ptr + 5'd1;
    end
    if (do_pop) rd_ptr <= rd_ptr + 5'd1;
    count <= count + {5'd0, do_push} - {5'd0, do_pop};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WIDTH:0] got [$];
  int             viol = 0;
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) got.push_back({m_last, m_data});
    if (link.read && ((m_valid && !m_ready) || link.fillStatus.empty)) viol <= viol + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    push      = 1'b1;
    push_data = d;
    tick();
    push      = 1'b0;
  endtask

  task automatic wait_bursts(input int n, input int budget);
    for (int i = 0; i < budget && bursts != 16'(n); i++) tick();
    check("wait_bursts", 32'(bursts), 32'(n));
  endtask

  task automatic check_stream(input string tag, input logic [31:0] base, input int n);
    check({tag, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      logic [WIDTH:0] e;
      e = got[i];
      check({tag, "_data"}, e[WIDTH-1:0], base + 32'(i));
      check({tag, "_last"}, 32'(e[WIDTH]), 32'(((i + 1) % BURST == 0) || (i == n - 1)));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    reset = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
    push = 1'b0; push_data = '0;
    tick(); tick();
    check("rst_valid",  32'(m_valid),     32'd0);
    check("rst_last",   32'(m_last),      32'd0);
    check("rst_data",   m_data,           32'd0);
    check("rst_busy",   32'(busy),        32'd0);
    check("rst_bursts", 32'(bursts),      32'd0);
    check("rst_read",   32'(link.read),   32'd0);
    check("rst_write",  32'(link.write),  32'd0);
    check("rst_datain", link.datain,      32'd0);
    reset = 1'b0;
    tick();

    // Full burst, ready held high: start at t, read at t+1, valid at t+2, no bubbles.
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(32'h10 + 32'(i));
    check("t1_fill", 32'(link.fillLevel), 32'd8);
    enable = 1'b1;
    check("t1_read_t",  32'(link.read), 32'd0);
    check("t1_busy_t",  32'(busy),      32'd0);
    tick();
    check("t1_busy_t1", 32'(busy),      32'd1);
    check("t1_read_t1", 32'(link.read), 32'd1);
    check("t1_valid_t1", 32'(m_valid),  32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("t1_valid", 32'(m_valid), 32'd1);
      check("t1_data",  m_data,       32'h10 + 32'(i));
      check("t1_last",  32'(m_last),  32'(i == 7));
      tick();
    end
    check("t1_bursts", 32'(bursts), 32'd1);
    check("t1_idle",   32'(busy),   32'd0);
    enable = 1'b0;

    // Alternating backpressure.
    for (int i = 0; i < 8; i++) push_word(32'h20 + 32'(i));
    got.delete();
    viol = 0;
    enable = 1'b1;
    for (int i = 0; i < 80 && bursts != 16'd2; i++) begin
      m_ready = i[0];
      tick();
    end
    m_ready = 1'b1;
    check("t2_bursts", 32'(bursts), 32'd2);
    check_stream("t2", 32'h20, 8);
    check("t2_read_viol", 32'(viol), 32'd0);

    // Timeout-forced partial burst: timer expires 16 cycles after the first word is visible.
    got.delete();
    push_word(32'h30);
    v = cyc;
    push_word(32'h31);
    push_word(32'h32);
    for (int i = 0; i < 40 && !m_valid; i++) tick();
    check("t3_latency", 32'(cyc - v), 32'd18);
    wait_bursts(3, 40);
    check_stream("t3", 32'h30, 3);
    enable = 1'b0;

    // Flush with 5 words, then flush with an empty fifo.
    for (int i = 0; i < 5; i++) push_word(32'h40 + 32'(i));
    got.delete();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_bursts(4, 40);
    check_stream("t4", 32'h40, 5);
    check("t4_fill", 32'(link.fillLevel), 32'd0);
    flush = 1'b1;
    check("t4e_read_f", 32'(link.read), 32'd0);
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t4e_busy", 32'(busy),      32'd0);
      check("t4e_read", 32'(link.read), 32'd0);
      tick();
    end
    check("t4e_bursts", 32'(bursts), 32'd4);

    // Completely full fifo drains as four 8-word bursts.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) push_word(32'h100 + 32'(i));
    check("t5_full", 32'(link.fillStatus.full), 32'd1);
    got.delete();
    viol = 0;
    enable = 1'b1;
    wait_bursts(4, 200);
    check_stream("t5", 32'h100, 32);
    check("t5_fill",  32'(link.fillLevel),        32'd0);
    check("t5_empty", 32'(link.fillStatus.empty), 32'd1);
    check("t5_read_viol", 32'(viol), 32'd0);
    enable = 1'b0;

    // Reset after three words popped: remaining words stay in the fifo.
    for (int i = 0; i < 8; i++) push_word(32'h200 + 32'(i));
    enable = 1'b1;
    for (int i = 0; i < 40 && link.fillLevel != 6'd5; i++) tick();
    check("t6_fill_pre", 32'(link.fillLevel), 32'd5);
    reset = 1'b1;
    tick();
    check("t6_valid",  32'(m_valid),        32'd0);
    check("t6_last",   32'(m_last),         32'd0);
    check("t6_busy",   32'(busy),           32'd0);
    check("t6_read",   32'(link.read),      32'd0);
    check("t6_bursts", 32'(bursts),         32'd0);
    check("t6_fill",   32'(link.fillLevel), 32'd5);
    reset  = 1'b0;
    enable = 1'b0;
    tick();
    check("t6_fill_after", 32'(link.fillLevel), 32'd5);
    check("t6_busy_after", 32'(busy),           32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Drains a `fifo` core through a `fifoConnect.reader` port and re-emits its contents as a valid/ready stream in bursts of `BURST` words, marking the last word of every burst. A burst starts when enough words are buffered, when a flush is requested, or when a partial fill has waited `TIMEOUT` cycles. The block sits on the consumer side of any FIFO and feeds DMA/packet engines that need bounded, framed transfers.

## Interface
- `WIDTH`, 32: data word width; must equal the connected interface's `WIDTH`.
- `DEPTH`, 32: depth of the connected FIFO; must equal the interface's `DEPTH`.
- `BURST`, 8: full burst length in words, range 1..`DEPTH`.
- `TIMEOUT`, 16: idle cycles before a partial burst is forced; 0 disables the timeout.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  allows new bursts to start; a burst already running always completes.
- `flush`  in  1  single-cycle pulse: emit whatever the FIFO holds (up to `BURST` words) as one burst.
- `link`  fifoConnect.reader  —  FIFO side. `write` and `datain` are driven to 0 permanently.
- `m_data`  out  `WIDTH`  stream data.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  downstream accepts `m_data` when `m_valid && m_ready`.
- `m_last`  out  1  marks the final word of a burst; qualified by `m_valid`.
- `busy`  out  1  high whenever the state is not IDLE.
- `bursts`  out  16  number of completed bursts; wraps modulo 2^16.

## Operation
- FIFO contract:
  - While `!link.fillStatus.empty`, `link.dataout` holds the head word.
  - Asserting `link.read` for one cycle pops exactly that word.
  - The new head and updated `fillLevel`/flags are visible on the next cycle.
- States are IDLE, BURST and DRAIN.
- IDLE, start conditions in priority order:
  - `enable && (fillLevel >= BURST || fillStatus.full)`: latch `remaining = BURST`.
  - `flush` or pending flush, with FIFO non-empty: latch `remaining = min(fillLevel, BURST)`.
  - Timeout expired and FIFO non-empty: latch `remaining = min(fillLevel, BURST)`.
  - Whichever applies moves the state to BURST.
  - `flush` with an empty FIFO is dropped silently. No read occurs.
- Timeout counter:
  - Counts in IDLE while `enable && !empty && fillLevel < BURST`.
  - Clears on an empty FIFO, on a burst start, or when `enable` is low.
  - Expires on reaching `TIMEOUT`.
- BURST:
  - `read = !empty && remaining != 0 && (!m_valid || m_ready)`.
  - On each read, `link.dataout` is captured into the output register, `m_valid` is set, and `remaining` decrements.
  - `m_last` is set with the word that takes `remaining` to 0. The state then moves to DRAIN.
  - If the FIFO is empty mid-burst, the block stalls in BURST with no read.
- DRAIN: waits for the `m_last` handshake, increments `bursts`, then returns to IDLE.
- A `flush` seen in BURST or DRAIN sets a pending-flush flag. The flag is served on the next IDLE cycle and cleared there.
- `m_valid` clears on handshake unless a new word is captured in the same cycle.
- `m_data` and `m_last` are held stable while `m_valid && !m_ready`.
- `remaining` is `$clog2(BURST+1)` bits wide. `fillLevel` compares are unsigned at `FILLBITS` width.

## Timing
- Reset values: `m_valid`=0, `m_last`=0, `m_data`=0, `busy`=0, `bursts`=0, `link.read`=0, state IDLE, counters 0, pending flush 0.
- A start condition true in IDLE at cycle t gives BURST with the first `read` at t+1 and the first `m_valid` at t+2.
- Throughput is 1 word/cycle with `m_ready` held high. There is no bubble inside a burst.
- Last pop at cycle n: `m_last` is valid at n+1. With `m_ready`=1, IDLE at n+2 and the earliest next `read` at n+3.
- `read` is never asserted while `m_valid && !m_ready`, nor while `empty`.
- Reset mid-burst: all outputs return to reset values on the next cycle. The output-register word is discarded, and unread words stay in the FIFO.

## Structure
- Shared package `libfifo_pkg`: `readerState_t` enum {IDLE, BURST, DRAIN}, next to the existing `fillStatus`/`fifoConnect` definitions.
- One sub-module, `stream_output_register` (parameterised on `WIDTH`). It holds `m_data`/`m_last`/`m_valid`, generates the `can_load = !m_valid || m_ready` signal, and is reused by other stream sources.

## Test plan
- BURST=8: write 0x10..0x17, hold `m_ready`=1 → `m_data` = 0x10..0x17 on 8 consecutive cycles, `m_last` only with 0x17, `bursts`=1.
- Same 8 words with `m_ready` alternating 1,0 → every word delivered once and in order; `read` is never high while `m_valid && !m_ready`.
- TIMEOUT=16, write 3 words → a 3-word burst begins 16 cycles after the first write is visible; `m_last` comes on the third word.
- `flush` with 5 words buffered → a 5-word burst. `flush` with an empty FIFO → `read` stays 0 and `busy` stays 0.
- Fill a 32-deep FIFO completely → four 8-word bursts, `m_last` on words 8/16/24/32, `bursts`=4, FIFO empty at the end.
- Assert `reset` after 3 words of an 8-word burst → next cycle `m_valid`=0, `busy`=0, `read`=0; `fillLevel` stays at 5.
